// File: rtl/lap_ram_if.sv
// RAM-side bus of the stopwatch lap memory: address, write data/enable and read data.
// master = lap_ram_ctrl (sole owner of address/data/wren); slave = the single-port RAM.
interface lap_ram_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 24
);
  // No backpressure: ram_wren is a write strobe that the RAM commits on every rising edge it is high,
  // and ram_q is trusted without a valid flag once the controller has held ram_address for RD_LAT cycles.
  logic [DEPTH_LOG2-1:0] ram_address;
  logic [DATA_W-1:0]     ram_data;
  logic                  ram_wren;
  logic [DATA_W-1:0]     ram_q;

  modport master (output ram_address, ram_data, ram_wren, input ram_q);
  modport slave  (input ram_address, ram_data, ram_wren, output ram_q);
endinterface

// File: rtl/lap_ram_ctrl.sv
// Lap RAM sequencer: stores laps, plays them back oldest..newest, bulk-clears the memory.
// Optional macro LAP_OVERWRITE_EN turns the lap store into a circular buffer when full.
module lap_ram_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 24,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk_50Mhz,
  input  logic                  rst,
  input  logic                  lap_req,
  input  logic [DATA_W-1:0]     time_in,
  input  logic                  recall_req,
  input  logic                  clear_req,
  lap_ram_if.master             ram,
  output logic [DATA_W-1:0]     recall_data,
  output logic                  recall_valid,
  output logic [DEPTH_LOG2:0]   lap_count,
  output logic                  full,
  output logic                  busy,
  output logic                  lap_drop,
  output logic [1:0]            dbg_state
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, CLEAR = 2'd3} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] address;
  logic [DATA_W-1:0]     data;
  logic                  wren;
  logic [CNT_W-1:0]      rd_cnt;
  logic [DEPTH_LOG2-1:0] oldest;
  logic                  can_store;

  assign full      = (lap_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign ram.ram_address = address;
  assign ram.ram_data    = data;
  assign ram.ram_wren    = wren;

`ifdef LAP_OVERWRITE_EN
  // Once wrapped, the next slot to be written is also the oldest surviving lap.
  assign oldest    = full ? wr_ptr : '0;
  assign can_store = 1'b1;
`else
  assign oldest    = '0;
  assign can_store = !full;
`endif

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      address      <= '0;
      data         <= '0;
      wren         <= 1'b0;
      rd_cnt       <= '0;
      recall_data  <= '0;
      recall_valid <= 1'b0;
      lap_count    <= '0;
      lap_drop     <= 1'b0;
    end else begin
      recall_valid <= 1'b0;
      lap_drop     <= busy && lap_req;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            wren     <= 1'b1;
            address  <= '0;
            data     <= '0;
            lap_drop <= lap_req;
          end else if (lap_req) begin
            if (can_store) begin
              state   <= WRITE;
              wren    <= 1'b1;
              address <= wr_ptr;
              data    <= time_in;
            end else begin
              lap_drop <= 1'b1;
            end
          end else if (recall_req && (lap_count != '0)) begin
            state   <= READ;
            address <= oldest + rd_ptr;
            rd_cnt  <= '0;
          end
        end
        WRITE: begin
          state   <= IDLE;
          wren    <= 1'b0;
          address <= '0;
          data    <= '0;
          wr_ptr  <= wr_ptr + 1'b1;
          // A write while full only happens in overwrite mode: playback restarts at the new oldest.
          if (!full) lap_count <= lap_count + 1'b1;
          else       rd_ptr    <= '0;
        end
        READ: begin
          if (rd_cnt == CNT_W'(RD_LAT - 1)) begin
            state        <= IDLE;
            address      <= '0;
            recall_data  <= ram.ram_q;
            recall_valid <= 1'b1;
            rd_ptr       <= ({1'b0, rd_ptr} == lap_count - 1'b1) ? '0 : rd_ptr + 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        CLEAR: begin
          if (address == DEPTH_LOG2'(DEPTH - 1)) begin
            state       <= IDLE;
            wren        <= 1'b0;
            address     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lap_count   <= '0;
            recall_data <= '0;
          end else begin
            address <= address + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lap_ram_ctrl.sv
// Directed bench for lap_ram_ctrl: vector table for lap/recall basics, hand sequences for
// full/overwrite, clear with a colliding lap, and reset in the middle of a clear.
module tb_lap_ram_ctrl;
  localparam int DL    = 4;
  localparam int DW    = 24;
  localparam int RL    = 2;
  localparam int DEPTH = 16;

  logic          clk_50Mhz = 1'b0;
  logic          rst = 1'b1;
  logic          lap_req = 1'b0;
  logic [DW-1:0] time_in = '0;
  logic          recall_req = 1'b0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] recall_data;
  logic          recall_valid;
  logic [DL:0]   lap_count;
  logic          full;
  logic          busy;
  logic          lap_drop;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  lap_ram_if #(.DEPTH_LOG2(DL), .DATA_W(DW)) ram_bus ();

  lap_ram_ctrl #(.DEPTH_LOG2(DL), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk_50Mhz    (clk_50Mhz),
    .rst          (rst),
    .lap_req      (lap_req),
    .time_in      (time_in),
    .recall_req   (recall_req),
    .clear_req    (clear_req),
    .ram          (ram_bus),
    .recall_data  (recall_data),
    .recall_valid (recall_valid),
    .lap_count    (lap_count),
    .full         (full),
    .busy         (busy),
    .lap_drop     (lap_drop),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / RAM model / write monitor ----------------
  always #10 clk_50Mhz = ~clk_50Mhz;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk_50Mhz) begin
    if (ram_bus.ram_wren) mem[ram_bus.ram_address] <= ram_bus.ram_data;
    ram_bus.ram_q <= mem[ram_bus.ram_address];
  end

  logic [DL+DW-1:0] wr_log [$];
  logic [DL+DW-1:0] exp_q  [$];
  always @(posedge clk_50Mhz)
    if (ram_bus.ram_wren) wr_log.push_back({ram_bus.ram_address, ram_bus.ram_data});

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwrites"}, wr_log.size(), exp_q.size());
    while (wr_log.size() > 0 && exp_q.size() > 0)
      chk({name, "_write"}, 32'(wr_log.pop_front()), 32'(exp_q.pop_front()));
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_wren"}, ram_bus.ram_wren, 0);
    chk({name, "_addr"}, ram_bus.ram_address, 0);
    chk({name, "_wdata"}, ram_bus.ram_data, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_count"}, lap_count, 0);
    chk({name, "_full"}, full, 0);
    chk({name, "_rdata"}, recall_data, 0);
    chk({name, "_valid"}, recall_valid, 0);
    chk({name, "_drop"}, lap_drop, 0);
    chk({name, "_state"}, dbg_state, 0);
  endtask

  // ---------------- driver ----------------
  // Pulses the requested inputs for one cycle, then watches until the controller returns idle.
  task automatic run_op(input logic c, input logic l, input logic r, input logic [DW-1:0] t,
                        output int n_valid, output logic [DW-1:0] data, output int n_drop,
                        output int busy_cyc, output int valid_at);
    bit done;
    n_valid = 0; data = '0; n_drop = 0; busy_cyc = 0; valid_at = 0; done = 0;
    @(negedge clk_50Mhz);
    clear_req = c; lap_req = l; recall_req = r; time_in = t;
    @(negedge clk_50Mhz);
    clear_req = 0; lap_req = 0; recall_req = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (recall_valid) begin n_valid++; data = recall_data; valid_at = k + 1; end
      if (lap_drop) n_drop++;
      if (busy) begin
        busy_cyc++;
        @(negedge clk_50Mhz);
      end else begin
        done = 1;
      end
    end
    if (!done) chk("op_timeout", 1, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          c, l, r;
    logic [DW-1:0] t;
    int            exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_drop;
    int            exp_busy;
    int            exp_count;
    logic          exp_wr;
    logic [DL-1:0] exp_waddr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int            nv, nd, bc, va;
    logic [DW-1:0] d;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 24'h0,      0, 24'h0,      0, 0,  0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h000105, 0, 24'h0,      0, 1,  1, 1'b1, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 24'h000210, 0, 24'h0,      0, 1,  2, 1'b1, 4'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 24'h000345, 0, 24'h0,      0, 1,  3, 1'b1, 4'd2};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 24'h0,      1, 24'h000105, 0, RL, 3, 1'b0, 4'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 24'h0,      1, 24'h000210, 0, RL, 3, 1'b0, 4'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 24'h0,      1, 24'h000345, 0, RL, 3, 1'b0, 4'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 24'h0,      1, 24'h000105, 0, RL, 3, 1'b0, 4'd0};

    // reset
    repeat (3) @(negedge clk_50Mhz);
    check_idle_outputs("reset");
    rst = 0;

    // lap / recall basics, including recall on an empty store
    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].l, vecs[i].r, vecs[i].t, nv, d, nd, bc, va);
      if (vecs[i].exp_wr) exp_q.push_back({vecs[i].exp_waddr, vecs[i].t});
      chk($sformatf("vec%0d_valid", i), nv, vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0) begin
        chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_latency", i), va, 1 + RL);
      end
      chk($sformatf("vec%0d_drop", i), nd, vecs[i].exp_drop);
      chk($sformatf("vec%0d_busy", i), bc, vecs[i].exp_busy);
      chk($sformatf("vec%0d_count", i), lap_count, vecs[i].exp_count);
      check_writes($sformatf("vec%0d", i));
    end

    // clear colliding with lap: clear wins, lap dropped, 16 zero writes
    run_op(1'b1, 1'b1, 1'b0, 24'h999999, nv, d, nd, bc, va);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({4'(a), 24'h0});
    chk("clear_drop", nd, 1);
    chk("clear_busy", bc, DEPTH);
    chk("clear_count", lap_count, 0);
    chk("clear_rdata", recall_data, 0);
    check_writes("clear");

    // fill to full
    for (int i = 1; i <= DEPTH; i++) begin
      run_op(1'b0, 1'b1, 1'b0, 24'(i), nv, d, nd, bc, va);
      exp_q.push_back({4'(i - 1), 24'(i)});
      if (i == DEPTH - 1) chk("fill15_full", full, 0);
    end
    chk("fill_count", lap_count, DEPTH);
    chk("fill_full", full, 1);
    check_writes("fill");

    // 17th lap on a full store
    run_op(1'b0, 1'b1, 1'b0, 24'h000017, nv, d, nd, bc, va);
`ifdef LAP_OVERWRITE_EN
    exp_q.push_back({4'd0, 24'h000017});
    chk("lap17_drop", nd, 0);
    chk("lap17_busy", bc, 1);
`else
    chk("lap17_drop", nd, 1);
    chk("lap17_busy", bc, 0);
`endif
    chk("lap17_count", lap_count, DEPTH);
    check_writes("lap17");
    run_op(1'b0, 1'b0, 1'b1, 24'h0, nv, d, nd, bc, va);
    chk("full_recall1_valid", nv, 1);
`ifdef LAP_OVERWRITE_EN
    chk("full_recall1_data", d, 24'd2);
`else
    chk("full_recall1_data", d, 24'd1);
`endif
    run_op(1'b0, 1'b0, 1'b1, 24'h0, nv, d, nd, bc, va);
`ifdef LAP_OVERWRITE_EN
    chk("full_recall2_data", d, 24'd3);
`else
    chk("full_recall2_data", d, 24'd2);
`endif

    // lap during clear is dropped; reset 5 cycles into the clear aborts it
    @(negedge clk_50Mhz); clear_req = 1;
    @(negedge clk_50Mhz); clear_req = 0;
    @(negedge clk_50Mhz); lap_req = 1; time_in = 24'h555555;
    @(negedge clk_50Mhz); lap_req = 0;
    chk("busy_lap_drop", lap_drop, 1);
    chk("clearing_busy", busy, 1);
    @(negedge clk_50Mhz);
    @(negedge clk_50Mhz);
    chk("clearing_wren", ram_bus.ram_wren, 1);
    #3 rst = 1;
    #1 check_idle_outputs("abort");
    for (int a = 0; a < 4; a++) exp_q.push_back({4'(a), 24'h0});
    check_writes("abort");
    @(negedge clk_50Mhz); rst = 0;
    run_op(1'b0, 1'b1, 1'b0, 24'h123456, nv, d, nd, bc, va);
    exp_q.push_back({4'd0, 24'h123456});
    chk("post_abort_count", lap_count, 1);
    check_writes("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
